bsram_pipe: RTL and testbench
=============================

BSRAM_PIPE -- requirements
Module: bsram_pipe

Interface
REQ-001 SHALL have parameter CORE, default 0: core index printed in report output.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width, multiple of 8; NB = DATA_WIDTH/8 byte lanes.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8: DEPTH = 2^ADDR_WIDTH words.
REQ-004 SHALL have parameter READ_LATENCY, default 1: legal values 1 or 2 cycles from accepted read to readValid.
REQ-005 SHALL have parameter INIT_ZERO, default 1: 1 = zero-fill sweep after reset; 0 = no sweep.
REQ-006 SHALL have port clock, input, 1 bit: the only clock; rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port readEnable, input, 1 bit: read request.
REQ-009 SHALL have port readAddress, input, ADDR_WIDTH bits: read word address.
REQ-010 SHALL have port writeEnable, input, 1 bit: write request.
REQ-011 SHALL have port writeByteEnable, input, NB bits: per-lane write mask; bit i covers data[8i+7:8i].
REQ-012 SHALL have port writeAddress, input, ADDR_WIDTH bits: write word address.
REQ-013 SHALL have port writeData, input, DATA_WIDTH bits: write data.
REQ-014 SHALL have port report, input, 1 bit: when high, prints a status block for that cycle.
REQ-015 SHALL have port ready, output, 1 bit: block accepts requests.
REQ-016 SHALL have port readValid, output, 1 bit: readData holds the result of an accepted read.
REQ-017 SHALL have port readData, output, DATA_WIDTH bits: read result.

Function
REQ-018 SHALL implement the FSM states CLEAR and RUN; ready = (state == RUN).
REQ-019 SHALL, in CLEAR, write all-zero to address clrCnt each cycle, with clrCnt counting 0..DEPTH-1, and enter RUN on the cycle after the write to DEPTH-1; CLEAR therefore lasts exactly DEPTH cycles.
REQ-020 SHALL ignore readEnable and writeEnable while ready=0: no memory update and no readValid.
REQ-021 SHALL, in RUN, accept a write when writeEnable=1: at the clock edge, update only the lanes with writeByteEnable=1 and leave the other lanes unchanged.
REQ-022 SHALL treat a write with writeByteEnable = 0 as a no-op.
REQ-023 SHALL, in RUN, accept a read when readEnable=1, with readValid=1 and readData valid exactly READ_LATENCY cycles after the accepting edge.
REQ-024 SHALL accept one read per cycle, fully pipelined, with no bubbles at READ_LATENCY=2.
REQ-025 SHALL, on a same-cycle read and write to the same address, return the byte-merged new word: enabled lanes from writeData, other lanes from the old contents.
REQ-026 SHALL make a write accepted at the edge before a read visible to that read (no stale data).
REQ-027 SHALL hold readData at its last valid value when readValid=0; readData is 0 until the first valid read.
REQ-028 SHALL keep a 32-bit cycle counter that clears on reset and wraps modulo 2^32.
REQ-029 SHALL, when report=1, print CORE, cycle count, state, ready, both ports' enables, addresses and data, and readValid.

Reset
REQ-030 SHALL, while reset=0 (asynchronous), force ready=0, readValid=0, readData=0, clrCnt=0, all read pipeline valid bits to 0, and the cycle counter to 0.
REQ-031 SHALL set state to CLEAR during reset when INIT_ZERO=1, and to RUN when INIT_ZERO=0; with INIT_ZERO=0, ready rises on the first edge after reset deasserts.
REQ-032 SHALL leave memory contents unchanged by reset itself; contents are zeroed only by the CLEAR sweep.
REQ-033 SHALL, on reset asserted mid-sweep or mid-read, drop in-flight reads without a readValid pulse and restart the sweep from address 0.

Verification
REQ-034 SHALL be covered by a bench scenario (DATA_WIDTH=32, ADDR_WIDTH=4, READ_LATENCY=2, INIT_ZERO=1): release reset -> ready=0 for 16 cycles, then 1; reads of addresses 0..15 return 0x00000000.
REQ-035 SHALL be covered by a bench scenario: write 0xDEADBEEF @3 BE=1111, then read @3 on the next cycle -> readValid=1 two cycles after the read edge with readData=0xDEADBEEF; then write 0x11223344 @3 BE=0101 and read -> 0xDE22BE44.
REQ-036 SHALL be covered by a bench scenario: @5 holds 0xAAAAAAAA; same-cycle write 0x000000FF BE=0001 and read @5 -> 0xAAAAAAFF, and a later read also returns 0xAAAAAAFF.
REQ-037 SHALL be covered by a bench scenario: back-to-back reads @1,@2,@3 holding 1,2,3 -> readValid high for 3 consecutive cycles with data 1,2,3 in order.
REQ-038 SHALL be covered by a bench scenario: assert reset at clrCnt=7, then release -> readValid=0 and ready=0 immediately; the sweep restarts at 0 and ready=1 after 16 cycles.
REQ-039 SHALL be covered by a bench scenario: writeEnable=1 (0x12345678 @9) and readEnable=1 during CLEAR -> no readValid; after RUN, reading @9 returns 0x00000000.

Source files
------------

// File: rtl/bsram_pipe.sv
// Byte-maskable single-clock RAM with a zero-fill sweep after reset and a pipelined read port.
// Read data arrives READ_LATENCY (1|2) cycles after acceptance; requests are dropped while ready=0.
module bsram_pipe #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    readEnable,
  input  logic [ADDR_WIDTH-1:0]   readAddress,
  input  logic                    writeEnable,
  input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
  input  logic [ADDR_WIDTH-1:0]   writeAddress,
  input  logic [DATA_WIDTH-1:0]   writeData,
  input  logic                    report,
  output logic                    ready,
  output logic                    readValid,
  output logic [DATA_WIDTH-1:0]   readData
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   clrCnt;
  logic [31:0]             cycle_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    rd_acc;
  logic                    wr_acc;
  logic                    wr_hit;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign rd_acc = ready & readEnable;
  assign wr_acc = ready & writeEnable;
  assign wr_hit = wr_acc && (writeAddress == readAddress);

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clrCnt == {ADDR_WIDTH{1'b1}}) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // ready is a flop so it stays low through reset even when the sweep is skipped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= (INIT_ZERO != 0) ? CLEAR : RUN;
      ready  <= 1'b0;
      clrCnt <= '0;
    end else begin
      state <= state_next;
      ready <= (state_next == RUN);
      if (state == CLEAR) clrCnt <= clrCnt + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clrCnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (writeByteEnable[i]) mem[writeAddress][8*i +: 8] <= writeData[8*i +: 8];
      end
    end
  end

  // Same-cycle write to the read address is merged lane by lane into the read result
  always_comb begin
    rd_word = mem[readAddress];
    if (wr_hit) begin
      for (int i = 0; i < NB; i++) begin
        if (writeByteEnable[i]) rd_word[8*i +: 8] = writeData[8*i +: 8];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_dat;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        s1_vld    <= 1'b0;
        s1_dat    <= '0;
        readValid <= 1'b0;
        readData  <= '0;
      end else begin
        s1_vld    <= rd_acc;
        if (rd_acc) s1_dat <= rd_word;
        readValid <= s1_vld;
        if (s1_vld) readData <= s1_dat;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        readValid <= 1'b0;
        readData  <= '0;
      end else begin
        readValid <= rd_acc;
        if (rd_acc) readData <= rd_word;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report) begin
      $display("bsram_pipe core=%0d cycle=%0d state=%s ready=%b rd_en=%b rd_addr=%0h wr_en=%b wr_be=%b wr_addr=%0h wr_data=%h rd_vld=%b rd_data=%h",
               CORE, cycle_cnt, state.name(), ready, readEnable, readAddress,
               writeEnable, writeByteEnable, writeAddress, writeData, readValid, readData);
    end
  end
`endif

endmodule

// File: tb/tb_bsram_pipe.sv
// Directed bench for bsram_pipe (32-bit words, 16 deep, two-cycle reads, zero-fill sweep).
module tb_bsram_pipe;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NB = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          readEnable = 1'b0;
  logic [AW-1:0] readAddress = '0;
  logic          writeEnable = 1'b0;
  logic [NB-1:0] writeByteEnable = '0;
  logic [AW-1:0] writeAddress = '0;
  logic [DW-1:0] writeData = '0;
  logic          report = 1'b0;
  logic          ready;
  logic          readValid;
  logic [DW-1:0] readData;

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n = 0;
  logic [31:0] last_dat = '0;

  bsram_pipe #(
    .CORE(0), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .INIT_ZERO(1)
  ) dut (
    .clock(clock), .reset(reset),
    .readEnable(readEnable), .readAddress(readAddress),
    .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
    .writeAddress(writeAddress), .writeData(writeData),
    .report(report), .ready(ready), .readValid(readValid), .readData(readData)
  );

  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h required=%h", tag, obs, want);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b required=%b", tag, obs, want);
    end
  endtask

  // Advance one edge, then compare against the scoreboard head (or expect a quiet, held output)
  task automatic cyc();
    @(posedge clock);
    cyc_n++;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc_n) begin
      check1("rd_vld", readValid, 1'b1);
      check32("rd_dat", readData, sb[0].dat);
      last_dat = sb[0].dat;
      void'(sb.pop_front());
    end else begin
      check1("no_vld", readValid, 1'b0);
      check32("rd_hold", readData, last_dat);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] want);
    readEnable  = 1'b1;
    readAddress = a;
    sb.push_back('{cyc_n + 2, want});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [NB-1:0] be);
    writeEnable     = 1'b1;
    writeAddress    = a;
    writeData       = d;
    writeByteEnable = be;
  endtask

  task automatic idle();
    readEnable      = 1'b0;
    writeEnable     = 1'b0;
    writeByteEnable = '0;
  endtask

  initial begin
    // held in reset
    repeat (3) cyc();
    check1("rst_ready", ready, 1'b0);

    // sweep with requests held active: none may be accepted
    reset = 1'b1;
    check1("rel_ready", ready, 1'b0);
    wr(4'd9, 32'h12345678, 4'hF);
    readEnable  = 1'b1;
    readAddress = 4'd9;
    for (int i = 0; i < 16; i++) begin
      cyc();
      check1("sweep_ready", ready, (i == 15));
    end
    idle();

    for (int a = 0; a < 16; a++) begin
      rd(AW'(a), 32'h0);
      cyc();
    end
    idle();
    repeat (3) cyc();

    // full write, read next cycle, then partial write
    wr(4'd3, 32'hDEADBEEF, 4'hF); cyc(); idle();
    rd(4'd3, 32'hDEADBEEF);       cyc(); idle();
    wr(4'd3, 32'h11223344, 4'h5); cyc(); idle();
    rd(4'd3, 32'hDE22BE44);       cyc(); idle();
    repeat (2) cyc();

    // same-cycle read/write merge, then empty-mask write
    wr(4'd5, 32'hAAAAAAAA, 4'hF); cyc(); idle();
    wr(4'd5, 32'h000000FF, 4'h1);
    rd(4'd5, 32'hAAAAAAFF);       cyc(); idle();
    wr(4'd5, 32'h00000000, 4'h0); cyc(); idle();
    rd(4'd5, 32'hAAAAAAFF);       cyc(); idle();
    repeat (2) cyc();

    // back-to-back reads
    wr(4'd1, 32'd1, 4'hF); cyc();
    wr(4'd2, 32'd2, 4'hF); cyc();
    wr(4'd3, 32'd3, 4'hF); cyc(); idle();
    rd(4'd1, 32'd1); cyc();
    rd(4'd2, 32'd2); cyc();
    rd(4'd3, 32'd3); cyc(); idle();
    report = 1'b1; cyc(); report = 1'b0;
    repeat (2) cyc();

    // write to another address in the same cycle must not disturb the read
    wr(4'd4, 32'hFFFFFFFF, 4'hF);
    rd(4'd2, 32'd2); cyc(); idle();
    rd(4'd4, 32'hFFFFFFFF); cyc(); idle();
    repeat (2) cyc();

    // reset with a read in flight
    rd(4'd1, 32'd1); cyc(); idle();
    reset = 1'b0;
    sb.delete();
    last_dat = '0;
    #1;
    check1("rst_mid_rd_vld", readValid, 1'b0);
    check32("rst_mid_rd_dat", readData, 32'h0);
    check1("rst_mid_rd_ready", ready, 1'b0);
    repeat (2) cyc();

    // reset at clrCnt=7, sweep must restart from 0
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check1("sweep1_ready", ready, 1'b0);
    end
    reset = 1'b0;
    #1;
    check1("rst_sweep_ready", ready, 1'b0);
    check1("rst_sweep_vld", readValid, 1'b0);
    cyc();
    reset = 1'b1;
    check1("rel2_ready", ready, 1'b0);
    check1("rel2_vld", readValid, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      check1("sweep2_ready", ready, (i == 15));
    end
    rd(4'd1, 32'h0); cyc();
    rd(4'd3, 32'h0); cyc();
    rd(4'd4, 32'h0); cyc();
    rd(4'd5, 32'h0); cyc(); idle();
    repeat (3) cyc();

    check32("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
